font16_rom_arbiter: RTL and testbench
=====================================

// Module: font16_rom_arbiter
// PURPOSE
//  Shares the single font16_rom (16 glyphs x 16 rows x 8 bits, 1-cycle read) between NUM_REQ
//  display requesters (score, timer, status overlays). Round-robin grant, one lookup per clock,
//  fully pipelined. Each response returns to its issuer with its row bitmap. Drives rom ce/oce/ad/reset.
// PARAMETERS
//  NUM_REQ     2   number of requesters, 2..8
//  IDX_W       1   $clog2(NUM_REQ), width of internal requester tag; must be >= 1
// PORTS
//  clk         in   1           system clock; all state on rising edge
//  reset       in   1           asynchronous, active-high; clears all state
//  en          in   1           1 = grants allowed; 0 = no new grants, in-flight lookups complete
//  req_valid   in   NUM_REQ     per-requester lookup request
//  req_glyph   in   4*NUM_REQ   glyph code, slice i for requester i (0-9 digits, 13-15 blank)
//  req_row     in   4*NUM_REQ   glyph row 0..15, slice i for requester i
//  req_ready   out  NUM_REQ     one-hot grant; handshake = req_valid[i] & req_ready[i]
//  resp_valid  out  NUM_REQ     one-hot, 1-cycle pulse: resp_data belongs to requester i
//  resp_data   out  8           row bitmap, MSB = leftmost pixel
//  rom_ce      out  1           to font16_rom ce
//  rom_oce     out  1           to font16_rom oce; tied 1
//  rom_reset   out  1           to font16_rom reset; equals reset
//  rom_ad      out  8           to font16_rom ad = {glyph, row}
//  rom_dout    in   8           from font16_rom dout
// BEHAVIOUR
//  Reset: req_ready=0, resp_valid=0, resp_data=8'h00, rom_ce=0, rom_ad=8'h00, rr pointer=0,
//   all pipeline valid bits 0. Reset mid-lookup discards in-flight responses; none emitted after.
//  Grant (combinational, cycle C): if en=0 then req_ready=0. Else scan req_valid starting at rr
//   pointer, wrapping NUM_REQ-1 -> 0; first set bit gets req_ready. At most one bit of req_ready;
//   req_ready[i] never asserted without req_valid[i]. No valids -> req_ready=0, pointer holds.
//  Pointer: on handshake of requester g, pointer <= (g==NUM_REQ-1) ? 0 : g+1 at end of C.
//  Stage 1 (edge ending C): rom_ad <= {req_glyph[g], req_row[g]}, rom_ce <= handshake,
//   s1_tag <= g, s1_vld <= handshake. When no handshake: rom_ce=0, rom_ad holds.
//  Stage 2: ROM registers data at edge ending C+1; rom_dout valid during C+2.
//  Stage 3 (edge ending C+2): resp_data <= rom_dout, resp_valid <= s2_vld ? onehot(s2_tag) : 0.
//   resp_data holds its last value while resp_valid=0.
//  Latency: handshake in cycle C -> resp_valid in cycle C+3. Throughput 1 lookup/clock; order
//   of responses == order of grants. No response backpressure: requester must take the pulse.
//  en falling: grants stop same cycle; up to 2 queued lookups still respond (drain).
//  Same requester granted back-to-back only when it is the sole valid requester.
//  req_glyph/req_row sampled only on handshake; changes while not granted are ignored.
// STRUCTURE
//  font16_pkg: GLYPH_W=4, ROW_W=4, ROM_AW=8, ROM_DW=8, ROM_LAT=1, RESP_LAT=3,
//   glyph constants GLYPH_0..GLYPH_9, GLYPH_BLANK=4'd13.
//  Sub-module rr_arbiter (NUM_REQ, IDX_W): req vector + en -> one-hot grant, grant index, pointer reg.
//  Top holds the stage-1/2/3 tag+valid shift registers and the ROM port registers.
//  font16_rom is instantiated by the parent, not inside this block.
// TESTING
//  Bench instantiates font16_rom behind this block; golden model = 256-byte table from font init.
//  1 Single req: req0 glyph=0 row=3, en=1 -> req_ready[0] same cycle, resp_valid=2'b01,
//    resp_data=8'hC6 exactly 3 cycles later; one pulse only.
//  2 Contention: req0 and req1 held valid 8 cycles -> grants alternate 0,1,0,1...; 8 responses,
//    tags alternate, each data matches golden table for that requester's {glyph,row}.
//  3 Back-to-back: req1 sweeps glyph=1 rows 0..15 alone -> 16 consecutive resp_valid=2'b10,
//    bytes equal to glyph 1 table rows in order, no bubbles.
//  4 en drop: 2 lookups issued, en=0 next cycle with valids held -> no further req_ready,
//    exactly 2 more responses, then resp_valid=0; en=1 resumes at rr pointer.
//  5 Async reset mid-flight: assert reset between grant and response -> resp_valid=0,
//    rom_ce=0 immediately; after release no stale response; first grant goes to requester 0.
//  6 Blank/wrap: glyph=15 row=15 -> rom_ad=8'hFF, resp_data=8'h00; NUM_REQ=3 pointer wraps 2->0.

Source files
------------

// File: rtl/font16_rom_arbiter_pkg.sv
// rtl/font16_rom_arbiter_pkg.sv - font16 ROM geometry, pipeline constants and glyph codes
package font16_rom_arbiter_pkg;

  localparam int GLYPH_W  = 4;
  localparam int ROW_W    = 4;
  localparam int ROM_AW   = 8;
  localparam int ROM_DW   = 8;
  localparam int ROM_LAT  = 1;
  localparam int RESP_LAT = 3;

  localparam logic [GLYPH_W-1:0] GLYPH_0     = 4'd0;
  localparam logic [GLYPH_W-1:0] GLYPH_1     = 4'd1;
  localparam logic [GLYPH_W-1:0] GLYPH_2     = 4'd2;
  localparam logic [GLYPH_W-1:0] GLYPH_3     = 4'd3;
  localparam logic [GLYPH_W-1:0] GLYPH_4     = 4'd4;
  localparam logic [GLYPH_W-1:0] GLYPH_5     = 4'd5;
  localparam logic [GLYPH_W-1:0] GLYPH_6     = 4'd6;
  localparam logic [GLYPH_W-1:0] GLYPH_7     = 4'd7;
  localparam logic [GLYPH_W-1:0] GLYPH_8     = 4'd8;
  localparam logic [GLYPH_W-1:0] GLYPH_9     = 4'd9;
  localparam logic [GLYPH_W-1:0] GLYPH_BLANK = 4'd13;

  typedef logic [GLYPH_W-1:0] glyph_t;
  typedef logic [ROW_W-1:0]   row_t;
  typedef logic [ROM_AW-1:0]  rom_addr_t;
  typedef logic [ROM_DW-1:0]  rom_data_t;

  function automatic rom_addr_t rom_addr(input glyph_t glyph, input row_t row);
    return {glyph, row};
  endfunction

endpackage

// File: rtl/font16_rom_arbiter_if.sv
// rtl/font16_rom_arbiter_if.sv - requester-side lookup request/response bundle
interface font16_rom_arbiter_if
  import font16_rom_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]         req_valid;
  logic [GLYPH_W*NUM_REQ-1:0] req_glyph;
  logic [ROW_W*NUM_REQ-1:0]   req_row;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         resp_valid;
  rom_data_t                  resp_data;

  modport master (
    output req_valid, req_glyph, req_row,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_glyph, req_row,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/font16_rom_arbiter_rr_arbiter.sv
// rtl/font16_rom_arbiter_rr_arbiter.sv - round-robin one-hot grant with rotating priority pointer
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;
  int               sum;

  // Scan from the pointer, wrapping; reset also blocks grants so req_ready is 0 while held.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    sum       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(ptr) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      cand = IDX_W'(sum);
      if (en && !reset && !grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (grant_vld) begin
      ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/font16_rom_arbiter.sv
// rtl/font16_rom_arbiter.sv - shares one font16 ROM among NUM_REQ requesters, 3-cycle pipelined lookups
module font16_rom_arbiter
  import font16_rom_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  font16_rom_arbiter_if.slave   bus,
  output logic                  rom_ce,
  output logic                  rom_oce,
  output logic                  rom_reset,
  output rom_addr_t             rom_ad,
  input  rom_data_t             rom_dout
);

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_vld;
  glyph_t             sel_glyph;
  row_t               sel_row;

  logic [IDX_W-1:0]   s1_tag;
  logic               s1_vld;
  logic [IDX_W-1:0]   s2_tag;
  logic               s2_vld;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .req       (bus.req_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign bus.req_ready = grant;
  assign rom_oce       = 1'b1;
  assign rom_reset     = reset;

  assign sel_glyph = bus.req_glyph[int'(grant_idx)*GLYPH_W +: GLYPH_W];
  assign sel_row   = bus.req_row[int'(grant_idx)*ROW_W +: ROW_W];

  // s1 tracks the address cycle, s2 the ROM register cycle; the tag rides alongside the data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_ce         <= 1'b0;
      rom_ad         <= '0;
      s1_tag         <= '0;
      s1_vld         <= 1'b0;
      s2_tag         <= '0;
      s2_vld         <= 1'b0;
      bus.resp_valid <= '0;
      bus.resp_data  <= '0;
    end else begin
      rom_ce <= grant_vld;
      s1_vld <= grant_vld;
      if (grant_vld) begin
        rom_ad <= rom_addr(sel_glyph, sel_row);
        s1_tag <= grant_idx;
      end
      s2_vld <= s1_vld;
      s2_tag <= s1_tag;
      bus.resp_valid <= s2_vld ? (NUM_REQ'(1) << s2_tag) : '0;
      if (s2_vld) bus.resp_data <= rom_dout;
    end
  end

endmodule

// File: tb/tb_font16_rom_arbiter.sv
// tb/tb_font16_rom_arbiter.sv - directed bench: two/three-requester arbiters over a behavioural font16 ROM
module tb_font16_rom_arbiter;
  import font16_rom_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic en2, en3;
  always #5 clk = ~clk;

  font16_rom_arbiter_if #(.NUM_REQ(2)) bus2 ();
  font16_rom_arbiter_if #(.NUM_REQ(3)) bus3 ();

  logic      rom_ce2, rom_oce2, rom_reset2, rom_ce3, rom_oce3, rom_reset3;
  rom_addr_t rom_ad2, rom_ad3;
  rom_data_t rom_dout2, rom_dout3;

  font16_rom_arbiter #(.NUM_REQ(2), .IDX_W(1)) dut2 (
    .clk(clk), .reset(reset), .en(en2), .bus(bus2),
    .rom_ce(rom_ce2), .rom_oce(rom_oce2), .rom_reset(rom_reset2),
    .rom_ad(rom_ad2), .rom_dout(rom_dout2)
  );

  font16_rom_arbiter #(.NUM_REQ(3), .IDX_W(2)) dut3 (
    .clk(clk), .reset(reset), .en(en3), .bus(bus3),
    .rom_ce(rom_ce3), .rom_oce(rom_oce3), .rom_reset(rom_reset3),
    .rom_ad(rom_ad3), .rom_dout(rom_dout3)
  );

  // Font contents: VGA-style 0 and 1, filler patterns for 2..12, blank 13..15.
  logic [7:0] glyph0_rows [16] = '{8'h00, 8'h00, 8'h7C, 8'hC6, 8'hC6, 8'hCE, 8'hDE, 8'hF6,
                                   8'hE6, 8'hC6, 8'hC6, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] glyph1_rows [16] = '{8'h00, 8'h00, 8'h18, 8'h38, 8'h78, 8'h18, 8'h18, 8'h18,
                                   8'h18, 8'h18, 8'h18, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] font_mem [256];

  initial begin
    for (int a = 0; a < 256; a++) begin
      if (a < 16)       font_mem[a] = glyph0_rows[a];
      else if (a < 32)  font_mem[a] = glyph1_rows[a-16];
      else if (a < 208) font_mem[a] = 8'((a * 37) + 1);
      else              font_mem[a] = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rom_reset2)   rom_dout2 <= 8'h00;
    else if (rom_ce2) rom_dout2 <= font_mem[rom_ad2];
    if (rom_reset3)   rom_dout3 <= 8'h00;
    else if (rom_ce3) rom_dout3 <= font_mem[rom_ad3];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       en;
    logic [1:0] valid;
    logic [7:0] glyph;
    logic [7:0] row;
    logic [1:0] exp_ready;
    logic [1:0] exp_rv;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [17];

  task automatic drive2(input logic e, input logic [1:0] v, input logic [7:0] g, input logic [7:0] r);
    en2 = e; bus2.req_valid = v; bus2.req_glyph = g; bus2.req_row = r;
  endtask

  initial begin
    // Contention (rows 0-11) then a single req0 lookup of glyph 0 row 3 (rows 12-16).
    vecs[0]  = '{1'b1, 2'b11, 8'h10, 8'h22, 2'b01, 2'b00, 8'h00};
    vecs[1]  = '{1'b1, 2'b11, 8'h10, 8'h33, 2'b10, 2'b00, 8'h00};
    vecs[2]  = '{1'b1, 2'b11, 8'h10, 8'h44, 2'b01, 2'b00, 8'h00};
    vecs[3]  = '{1'b1, 2'b11, 8'h10, 8'h55, 2'b10, 2'b01, 8'h7C};
    vecs[4]  = '{1'b1, 2'b11, 8'h10, 8'h66, 2'b01, 2'b10, 8'h38};
    vecs[5]  = '{1'b1, 2'b11, 8'h10, 8'h77, 2'b10, 2'b01, 8'hC6};
    vecs[6]  = '{1'b1, 2'b11, 8'h10, 8'h88, 2'b01, 2'b10, 8'h18};
    vecs[7]  = '{1'b1, 2'b11, 8'h10, 8'h99, 2'b10, 2'b01, 8'hDE};
    vecs[8]  = '{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b10, 8'h18};
    vecs[9]  = '{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b01, 8'hE6};
    vecs[10] = '{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b10, 8'h18};
    vecs[11] = '{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h18};
    vecs[12] = '{1'b1, 2'b01, 8'h00, 8'h03, 2'b01, 2'b00, 8'h18};
    vecs[13] = '{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h18};
    vecs[14] = '{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h18};
    vecs[15] = '{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b01, 8'hC6};
    vecs[16] = '{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'hC6};

    reset = 1'b1;
    drive2(1'b1, 2'b11, 8'h10, 8'h33);
    en3 = 1'b0; bus3.req_valid = '0; bus3.req_glyph = '0; bus3.req_row = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", bus2.req_ready, 2'b00);
    chk("reset_resp_valid", bus2.resp_valid, 2'b00);
    chk("reset_resp_data", bus2.resp_data, 8'h00);
    chk("reset_rom_ce", rom_ce2, 1'b0);
    chk("reset_rom_ad", rom_ad2, 8'h00);
    chk("rom_oce_tied", rom_oce2, 1'b1);
    chk("rom_reset_follows", rom_reset2, 1'b1);
    drive2(1'b1, 2'b00, 8'h00, 8'h00);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      drive2(vecs[i].en, vecs[i].valid, vecs[i].glyph, vecs[i].row);
      @(negedge clk);
      chk($sformatf("vec%0d_req_ready", i), bus2.req_ready, vecs[i].exp_ready);
      chk($sformatf("vec%0d_resp_valid", i), bus2.resp_valid, vecs[i].exp_rv);
      chk($sformatf("vec%0d_resp_data", i), bus2.resp_data, vecs[i].exp_rd);
    end

    // Requester 1 alone sweeps glyph 1 rows 0..15; responses must stream with no bubbles.
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      if (t < 16) drive2(1'b1, 2'b10, 8'h10, {4'(t), 4'h0});
      else        drive2(1'b1, 2'b00, 8'h00, 8'h00);
      @(negedge clk);
      chk($sformatf("sweep%0d_req_ready", t), bus2.req_ready, (t < 16) ? 2'b10 : 2'b00);
      if (t >= 3 && t <= 18) begin
        chk($sformatf("sweep%0d_resp_valid", t), bus2.resp_valid, 2'b10);
        chk($sformatf("sweep%0d_resp_data", t), bus2.resp_data, font_mem[16 + t - 3]);
      end else begin
        chk($sformatf("sweep%0d_resp_valid", t), bus2.resp_valid, 2'b00);
      end
    end

    // en drop after two grants: two responses drain, then grants resume at the pointer.
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      drive2((j < 2) || (j == 7), 2'b11, 8'h10, 8'h43);
      @(negedge clk);
      chk($sformatf("endrop%0d_req_ready", j), bus2.req_ready,
          (j == 0 || j == 7) ? 2'b01 : (j == 1) ? 2'b10 : 2'b00);
      chk($sformatf("endrop%0d_resp_valid", j), bus2.resp_valid,
          (j == 3) ? 2'b01 : (j == 4) ? 2'b10 : 2'b00);
      if (j == 3) chk("endrop_data0", bus2.resp_data, 8'hC6);
      if (j == 4) chk("endrop_data1", bus2.resp_data, 8'h78);
    end

    // Reset lands one cycle after the resume grant to requester 0.
    @(posedge clk); #1;
    drive2(1'b1, 2'b00, 8'h00, 8'h00);
    chk("midflight_rom_ce_before", rom_ce2, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("midflight_rom_ce", rom_ce2, 1'b0);
    chk("midflight_resp_valid", bus2.resp_valid, 2'b00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("post_reset%0d_resp_valid", k), bus2.resp_valid, 2'b00);
    end
    @(posedge clk); #1;
    drive2(1'b1, 2'b11, 8'h00, 8'h00);
    @(negedge clk);
    chk("post_reset_first_grant", bus2.req_ready, 2'b01);
    @(posedge clk); #1;
    drive2(1'b0, 2'b00, 8'h00, 8'h00);

    // Three requesters: blank glyph 15 row 15 on requester 2, then pointer wraps 2 -> 0.
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      en3 = 1'b1;
      bus3.req_glyph = 12'hF10;
      bus3.req_row   = 12'hF33;
      case (j)
        0, 3:    bus3.req_valid = 3'b111;
        1:       bus3.req_valid = 3'b110;
        2:       bus3.req_valid = 3'b100;
        default: bus3.req_valid = 3'b000;
      endcase
      @(negedge clk);
      chk($sformatf("n3_%0d_req_ready", j), bus3.req_ready,
          (j == 0 || j == 3) ? 3'b001 : (j == 1) ? 3'b010 : (j == 2) ? 3'b100 : 3'b000);
      chk($sformatf("n3_%0d_resp_valid", j), bus3.resp_valid,
          (j == 3 || j == 6) ? 3'b001 : (j == 4) ? 3'b010 : (j == 5) ? 3'b100 : 3'b000);
      if (j == 3) chk("n3_rom_ad_blank", rom_ad3, 8'hFF);
      if (j == 3) chk("n3_data_req0", bus3.resp_data, 8'hC6);
      if (j == 4) chk("n3_data_req1", bus3.resp_data, 8'h38);
      if (j == 5) chk("n3_data_blank", bus3.resp_data, 8'h00);
      if (j == 6) chk("n3_data_wrap", bus3.resp_data, 8'hC6);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
